// File: rtl/rename_map.sv
// Register alias table with a circular free list, one speculation checkpoint
// and two retire ports; renames up to two instructions per cycle.
module rename_map #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int FREE_DEPTH = 32,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int FW = $clog2(FREE_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           q_valid,
    input  logic [1:0][AW-1:0]   q_rs_1,
    input  logic [1:0][AW-1:0]   q_rs_2,
    input  logic [1:0][AW-1:0]   q_rd,
    input  logic [1:0]           q_rename,
    input  logic [1:0]           q_tag,
    input  logic                 checkpoint,
    input  logic                 flush,
    input  logic [1:0]           free_valid,
    input  logic [1:0][PW-1:0]   free_rn,
    output logic [1:0]           r_valid,
    output logic [1:0][PW-1:0]   r_rs_1_rn,
    output logic [1:0][PW-1:0]   r_rs_2_rn,
    output logic [1:0][PW-1:0]   r_rd_rn,
    output logic [1:0][PW-1:0]   r_prev_rn,
    output logic [1:0]           r_tag,
    output logic                 stall,
    output logic [FW:0]          free_count
);

    logic [PW-1:0] map_r      [ARCH_REGS];
    logic [PW-1:0] snap_map_r [ARCH_REGS];
    logic [PW-1:0] map_next_s [ARCH_REGS];
    logic [PW-1:0] fifo_r     [FREE_DEPTH];
    logic [FW-1:0] head_r, tail_r, snap_head_r, tail1_s;
    logic [FW:0]   count_r, snap_count_r, pushed_since_r;
    logic [FW:0]   need_s, pushed_s, count_next_s;
    logic [1:0]    alloc_s, push_s, byp_s;
    logic          accept_s;
    logic [1:0][PW-1:0] new_rn_s, rs1_s, rs2_s, rd_s, prev_s, rd_map_s;

    // x0 always reads as rn 0; slot 1 sees slot 0's fresh rn for a matching register
    function automatic logic [PW-1:0] lookup(input logic [PW-1:0] mapped,
                                             input logic [AW-1:0] areg,
                                             input logic          byp,
                                             input logic [AW-1:0] byp_reg,
                                             input logic [PW-1:0] byp_rn);
        logic [PW-1:0] rn;
        if (areg == {AW{1'b0}}) begin
            rn = {PW{1'b0}};
        end else if (byp && (areg == byp_reg)) begin
            rn = byp_rn;
        end else begin
            rn = mapped;
        end
        return rn;
    endfunction

    // Allocation demand, acceptance, retire pushes and candidate free-list entries
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            alloc_s[i] = q_valid[i] & q_rename[i] & (q_rd[i] != {AW{1'b0}});
            push_s[i]  = free_valid[i] & (free_rn[i] != {PW{1'b0}});
        end
        byp_s        = {alloc_s[0], 1'b0};
        need_s       = {{FW{1'b0}}, alloc_s[0]} + {{FW{1'b0}}, alloc_s[1]};
        pushed_s     = {{FW{1'b0}}, push_s[0]} + {{FW{1'b0}}, push_s[1]};
        accept_s     = (count_r >= need_s) && !flush;
        stall        = (need_s != {(FW+1){1'b0}}) && !accept_s;
        count_next_s = count_r - need_s + pushed_s;
        tail1_s      = tail_r + {{(FW-1){1'b0}}, push_s[0]};
        new_rn_s[0]  = fifo_r[head_r];
        new_rn_s[1]  = fifo_r[head_r + {{(FW-1){1'b0}}, alloc_s[0]}];
    end

    // Per-slot rename results, zeroed for invalid slots
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_map_s[i] = lookup(map_r[q_rd[i]], q_rd[i], byp_s[i], q_rd[0], new_rn_s[0]);
            if (!q_valid[i]) begin
                rs1_s[i]  = {PW{1'b0}};
                rs2_s[i]  = {PW{1'b0}};
                rd_s[i]   = {PW{1'b0}};
                prev_s[i] = {PW{1'b0}};
            end else begin
                rs1_s[i] = lookup(map_r[q_rs_1[i]], q_rs_1[i], byp_s[i], q_rd[0], new_rn_s[0]);
                rs2_s[i] = lookup(map_r[q_rs_2[i]], q_rs_2[i], byp_s[i], q_rd[0], new_rn_s[0]);
                if (alloc_s[i]) begin
                    rd_s[i]   = new_rn_s[i];
                    prev_s[i] = rd_map_s[i];
                end else begin
                    rd_s[i]   = rd_map_s[i];
                    prev_s[i] = {PW{1'b0}};
                end
            end
        end
    end

    // Map after this cycle's renames; slot 1 wins a same-rd write
    always_comb begin
        for (int j = 0; j < ARCH_REGS; j++) begin
            map_next_s[j] = (accept_s && alloc_s[1] && (q_rd[1] == AW'(j))) ? new_rn_s[1] :
                            (accept_s && alloc_s[0] && (q_rd[0] == AW'(j))) ? new_rn_s[0] :
                            map_r[j];
        end
    end

    // Map, free list, counters and checkpoint state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_r[i]      <= PW'(i);
                snap_map_r[i] <= PW'(i);
            end
            for (int i = 0; i < FREE_DEPTH; i++) begin
                fifo_r[i] <= PW'(ARCH_REGS + i);
            end
            head_r         <= {FW{1'b0}};
            tail_r         <= {FW{1'b0}};
            snap_head_r    <= {FW{1'b0}};
            count_r        <= (FW+1)'(FREE_DEPTH);
            snap_count_r   <= (FW+1)'(FREE_DEPTH);
            pushed_since_r <= {(FW+1){1'b0}};
        end else begin
            if (push_s[0]) fifo_r[tail_r]  <= free_rn[0];
            if (push_s[1]) fifo_r[tail1_s] <= free_rn[1];
            tail_r <= tail_r + pushed_s[FW-1:0];
            if (flush) begin
                // restored occupancy = snapshot count plus every retire since it was taken
                for (int i = 0; i < ARCH_REGS; i++) map_r[i] <= snap_map_r[i];
                head_r         <= snap_head_r;
                count_r        <= snap_count_r + pushed_since_r + pushed_s;
                pushed_since_r <= pushed_since_r + pushed_s;
            end else if (accept_s) begin
                for (int i = 0; i < ARCH_REGS; i++) map_r[i] <= map_next_s[i];
                head_r  <= head_r + need_s[FW-1:0];
                count_r <= count_next_s;
                if (checkpoint) begin
                    for (int i = 0; i < ARCH_REGS; i++) snap_map_r[i] <= map_next_s[i];
                    snap_head_r    <= head_r + need_s[FW-1:0];
                    snap_count_r   <= count_next_s;
                    pushed_since_r <= {(FW+1){1'b0}};
                end else begin
                    pushed_since_r <= pushed_since_r + pushed_s;
                end
            end else begin
                count_r        <= count_r + pushed_s;
                pushed_since_r <= pushed_since_r + pushed_s;
            end
        end
    end

    // Registered results
    always_ff @(posedge clock) begin
        if (reset || !accept_s) begin
            r_valid   <= 2'b00;
            r_rs_1_rn <= '0;
            r_rs_2_rn <= '0;
            r_rd_rn   <= '0;
            r_prev_rn <= '0;
            r_tag     <= 2'b00;
        end else begin
            r_valid   <= q_valid;
            r_rs_1_rn <= rs1_s;
            r_rs_2_rn <= rs2_s;
            r_rd_rn   <= rd_s;
            r_prev_rn <= prev_s;
            r_tag     <= q_tag & q_valid;
        end
    end

    assign free_count = count_r;

endmodule
